// File: rtl/lsu_ctrl_if.sv
// lsu_ctrl_if: word-wide data memory request/acknowledge bus.
// The load/store controller is the master and the memory is the slave.
interface lsu_ctrl_if #(parameter int AW = 32);
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_be;
    logic [31:0]   mem_wdata;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );
    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store controller between decoder and data memory.
// Runs one req/ack memory access per instruction, stalls via o_busy, sign-extends loads.
module lsu_ctrl #(
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_req_valid,
    input  logic          i_memwrite,
    input  logic          i_memtoreg,
    input  logic          i_half,
    input  logic          i_b,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic          o_busy,
    output logic          o_done,
    output logic [31:0]   o_rdata,
    output logic          o_misalign,
    lsu_ctrl_if.master    mem
);
    typedef enum logic [1:0] {IDLE, REQ, DONE, ERR} state_t;

    state_t        r_state;
    logic          r_mem_req;
    logic          r_we;
    logic [AW-1:0] r_addr;
    logic [3:0]    r_be;
    logic [31:0]   r_wdata;
    logic [31:0]   r_rdata;
    logic [1:0]    r_off;
    logic          r_byte;
    logic          r_half;
    logic          r_done;
    logic          r_misalign;

    logic        w_valid;
    logic        w_byte;
    logic        w_half;
    logic        w_mis;
    logic [3:0]  w_be;
    logic [31:0] w_wdata;
    logic [7:0]  w_b8;
    logic [15:0] w_h16;
    logic [31:0] w_ld;

    // byte wins over half; a store takes priority when both direction bits are set
    assign w_valid = i_req_valid & (i_memwrite | i_memtoreg);
    assign w_byte  = i_b;
    assign w_half  = ~i_b & i_half;
    assign w_mis   = w_half ? i_addr[0] : (~w_byte & (|i_addr[1:0]));
    assign w_be    = ~i_memwrite ? 4'b1111 :
                     w_byte      ? 4'b0001 << i_addr[1:0] :
                     w_half      ? (i_addr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    assign w_wdata = w_byte ? {4{i_wdata[7:0]}} :
                     w_half ? {2{i_wdata[15:0]}} : i_wdata;

    assign w_b8  = r_off[1] ? (r_off[0] ? mem.mem_rdata[31:24] : mem.mem_rdata[23:16])
                            : (r_off[0] ? mem.mem_rdata[15:8]  : mem.mem_rdata[7:0]);
    assign w_h16 = r_off[1] ? mem.mem_rdata[31:16] : mem.mem_rdata[15:0];
    assign w_ld  = r_byte ? {{24{w_b8[7]}}, w_b8} :
                   r_half ? {{16{w_h16[15]}}, w_h16} : mem.mem_rdata;

    assign o_busy = (r_state == IDLE && w_valid) || r_state == REQ || r_state == ERR;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_mem_req  <= 1'b0;
            r_we       <= 1'b0;
            r_addr     <= '0;
            r_be       <= 4'b0000;
            r_wdata    <= 32'h0;
            r_rdata    <= 32'h0;
            r_off      <= 2'b00;
            r_byte     <= 1'b0;
            r_half     <= 1'b0;
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_misalign <= 1'b0;
            case (r_state)
                IDLE: if (w_valid) begin
                    if (w_mis) begin
                        r_state    <= ERR;
                        r_misalign <= 1'b1;
                    end else begin
                        r_state   <= REQ;
                        r_mem_req <= 1'b1;
                        r_we      <= i_memwrite;
                        r_addr    <= {i_addr[AW-1:2], 2'b00};
                        r_be      <= w_be;
                        r_wdata   <= w_wdata;
                        r_off     <= i_addr[1:0];
                        r_byte    <= w_byte;
                        r_half    <= w_half;
                    end
                end
                REQ: if (mem.mem_ack) begin
                    r_state   <= DONE;
                    r_mem_req <= 1'b0;
                    r_we      <= 1'b0;
                    r_done    <= 1'b1;
                    if (!r_we) r_rdata <= w_ld;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign mem.mem_req   = r_mem_req;
    assign mem.mem_we    = r_we;
    assign mem.mem_addr  = r_addr;
    assign mem.mem_be    = r_be;
    assign mem.mem_wdata = r_wdata;
    assign o_done        = r_done;
    assign o_misalign    = r_misalign;
    assign o_rdata       = r_rdata;
endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven directed vectors for lsu_ctrl with hand-computed expectations,
// plus hand sequences for reset mid-transaction and stray acknowledges.
module tb_lsu_ctrl;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0, memwrite = 1'b0, memtoreg = 1'b0, half = 1'b0, b = 1'b0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        busy, done, misalign;
    logic [31:0] rdata;
    int          total = 0, bad = 0;
    logic [31:0] last_rd;

    lsu_ctrl_if #(.AW(32)) m();

    lsu_ctrl #(.AW(32)) dut (
        .clk(clk), .reset(reset),
        .i_req_valid(req_valid), .i_memwrite(memwrite), .i_memtoreg(memtoreg),
        .i_half(half), .i_b(b), .i_addr(addr), .i_wdata(wdata),
        .o_busy(busy), .o_done(done), .o_rdata(rdata), .o_misalign(misalign),
        .mem(m)
    );

    always #5 clk = ~clk;

    // kind: 0 ignored, 1 memory access, 2 alignment fault
    typedef struct {
        int          kind;
        logic        wr, rd, hf, by;
        logic [31:0] a, wd, mrd;
        int          nwait;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata, e_rdata;
    } vec_t;

    vec_t vt[14];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // called just after a rising edge; returns just after a rising edge
    task automatic run(input int id, input vec_t v);
        req_valid = 1'b1; memwrite = v.wr; memtoreg = v.rd; half = v.hf; b = v.by;
        addr = v.a; wdata = v.wd;
        @(negedge clk);
        chk($sformatf("v%0d_busy0", id), {31'b0, busy}, {31'b0, v.kind != 0});
        @(posedge clk); #1;
        req_valid = 1'b0;
        if (v.kind == 1) begin
            for (int k = 0; k <= v.nwait; k++) begin
                m.mem_ack = (k == v.nwait);
                m.mem_rdata = v.mrd;
                @(negedge clk);
                chk($sformatf("v%0d_req%0d", id, k), {31'b0, m.mem_req}, 32'd1);
                chk($sformatf("v%0d_busy_req%0d", id, k), {31'b0, busy}, 32'd1);
                chk($sformatf("v%0d_addr%0d", id, k), m.mem_addr, v.e_addr);
                chk($sformatf("v%0d_be%0d", id, k), {28'b0, m.mem_be}, {28'b0, v.e_be});
                chk($sformatf("v%0d_we%0d", id, k), {31'b0, m.mem_we}, {31'b0, v.wr});
                if (v.wr) chk($sformatf("v%0d_wdata%0d", id, k), m.mem_wdata, v.e_wdata);
                chk($sformatf("v%0d_nodone%0d", id, k), {31'b0, done}, 32'd0);
                @(posedge clk); #1;
            end
            m.mem_ack = 1'b0;
            if (!v.wr) last_rd = v.e_rdata;
            @(negedge clk);
            chk($sformatf("v%0d_done", id), {31'b0, done}, 32'd1);
            chk($sformatf("v%0d_busy_done", id), {31'b0, busy}, 32'd0);
            chk($sformatf("v%0d_req_off", id), {31'b0, m.mem_req}, 32'd0);
            chk($sformatf("v%0d_rdata", id), rdata, last_rd);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("v%0d_done_pulse", id), {31'b0, done}, 32'd0);
            @(posedge clk); #1;
        end else if (v.kind == 2) begin
            @(negedge clk);
            chk($sformatf("v%0d_mis", id), {31'b0, misalign}, 32'd1);
            chk($sformatf("v%0d_mis_noreq", id), {31'b0, m.mem_req}, 32'd0);
            chk($sformatf("v%0d_mis_busy", id), {31'b0, busy}, 32'd1);
            chk($sformatf("v%0d_mis_rdata", id), rdata, last_rd);
            @(posedge clk); #1;
            @(negedge clk);
            chk($sformatf("v%0d_mis_pulse", id), {31'b0, misalign}, 32'd0);
            chk($sformatf("v%0d_mis_idle", id), {31'b0, busy}, 32'd0);
            @(posedge clk); #1;
        end else begin
            @(negedge clk);
            chk($sformatf("v%0d_ign_req", id), {31'b0, m.mem_req}, 32'd0);
            chk($sformatf("v%0d_ign_done", id), {31'b0, done}, 32'd0);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        //            kind wr rd hf by addr          wdata         mem_rdata     w  e_addr        e_be     e_wdata       e_rdata
        vt[0]  = '{1, 0, 1, 0, 1, 32'h0000_1003, 32'h0,        32'h80FF_1234, 0, 32'h0000_1000, 4'b1111, 32'h0,        32'hFFFF_FF80};
        vt[1]  = '{1, 0, 1, 1, 0, 32'h0000_2002, 32'h0,        32'h7ABC_0000, 3, 32'h0000_2000, 4'b1111, 32'h0,        32'h0000_7ABC};
        vt[2]  = '{1, 1, 0, 0, 1, 32'h0000_0011, 32'h0000_00AB, 32'h0,        0, 32'h0000_0010, 4'b0010, 32'hABAB_ABAB, 32'h0};
        vt[3]  = '{2, 0, 1, 0, 0, 32'h0000_0006, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[4]  = '{1, 1, 0, 1, 0, 32'h0000_0022, 32'h1234_5678, 32'h0,        1, 32'h0000_0020, 4'b1100, 32'h5678_5678, 32'h0};
        vt[5]  = '{1, 1, 1, 0, 0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0,        0, 32'h0000_0040, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vt[6]  = '{1, 0, 1, 1, 0, 32'h0000_0100, 32'h0,        32'h1234_8001, 1, 32'h0000_0100, 4'b1111, 32'h0,        32'hFFFF_8001};
        vt[7]  = '{1, 0, 1, 1, 1, 32'h0000_0201, 32'h0,        32'h0000_7F00, 0, 32'h0000_0200, 4'b1111, 32'h0,        32'h0000_007F};
        vt[8]  = '{1, 0, 1, 0, 0, 32'h0000_0300, 32'h0,        32'hCAFE_F00D, 2, 32'h0000_0300, 4'b1111, 32'h0,        32'hCAFE_F00D};
        vt[9]  = '{2, 1, 0, 1, 0, 32'h0000_0013, 32'h0000_1111, 32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[10] = '{0, 0, 0, 0, 0, 32'h0000_0400, 32'h0,        32'h0,        0, 32'h0,        4'b0000, 32'h0,        32'h0};
        vt[11] = '{1, 1, 0, 0, 1, 32'h0000_0003, 32'h0000_01FF, 32'h0,        0, 32'h0000_0000, 4'b1000, 32'hFFFF_FFFF, 32'h0};
        vt[12] = '{1, 0, 1, 0, 1, 32'h0000_0000, 32'h0,        32'h1234_567F, 0, 32'h0000_0000, 4'b1111, 32'h0,        32'h0000_007F};
        vt[13] = '{1, 0, 1, 1, 0, 32'h0000_0A02, 32'h0,        32'hFFFE_0000, 0, 32'h0000_0A00, 4'b1111, 32'h0,        32'hFFFF_FFFE};
        m.mem_ack = 1'b0;
        m.mem_rdata = 32'h0;
        last_rd = 32'h0;
        #12;
        chk("rst_req", {31'b0, m.mem_req}, 32'd0);
        chk("rst_we", {31'b0, m.mem_we}, 32'd0);
        chk("rst_be", {28'b0, m.mem_be}, 32'd0);
        chk("rst_addr", m.mem_addr, 32'd0);
        chk("rst_wdata", m.mem_wdata, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_mis", {31'b0, misalign}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 14; i++) run(i, vt[i]);
        // stray acknowledge while idle
        m.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("stray_done%0d", k), {31'b0, done}, 32'd0);
            chk($sformatf("stray_req%0d", k), {31'b0, m.mem_req}, 32'd0);
            @(posedge clk); #1;
        end
        m.mem_ack = 1'b0;
        // reset asserted while waiting for ack
        req_valid = 1'b1; memwrite = 1'b0; memtoreg = 1'b1; half = 1'b0; b = 1'b0;
        addr = 32'h0000_0500;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(negedge clk);
        chk("mid_req_on", {31'b0, m.mem_req}, 32'd1);
        #1;
        reset = 1'b0;
        #1;
        chk("mid_rst_req", {31'b0, m.mem_req}, 32'd0);
        chk("mid_rst_rdata", rdata, 32'd0);
        last_rd = 32'h0;
        @(posedge clk); #1;
        reset = 1'b1;
        m.mem_ack = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("post_rst_done%0d", k), {31'b0, done}, 32'd0);
            chk($sformatf("post_rst_busy%0d", k), {31'b0, busy}, 32'd0);
            @(posedge clk); #1;
        end
        m.mem_ack = 1'b0;
        run(20, '{1, 0, 1, 0, 0, 32'h0000_0504, 32'h0, 32'h0102_0304, 1, 32'h0000_0504, 4'b1111, 32'h0, 32'h0102_0304});
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
